// File: rtl/bin_bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
// Holds the FSM state type, the BCD digit type and a constant function
// that reports how many decimal digits a binary width needs.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int MIN_BIN_W = 4;
  localparam int MAX_BIN_W = 32;

  // Number of decimal digits needed to print 2**width - 1.
  function automatic int bcd_digits_for(input int width);
    longint unsigned v;
    int              n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    while (v != 64'd0) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Per-digit correction used by the shift-and-add-3 (double dabble) step:
// any digit above 4 gets 3 added so the following left shift carries
// correctly into the next decimal digit.
module bcd_add3_digit
  import bin_bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  // Add 3 to digits 5..15, pass 0..4 unchanged.
  always_comb begin
    digit_out = digit_in;
    if (digit_in > 4'd4) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_iter.sv
// Iterative binary-to-BCD converter, one double-dabble step per clock.
// Valid/ready handshake on both sides; IDLE -> CONV (BIN_W shifts) -> DONE.
// Optional macro BIN_BCD_SIGNED_EN: bin_in is two's complement, the
// magnitude is converted and neg carries the sign. Without it the input is
// unsigned and neg is tied low.
module bin_to_bcd_iter
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Parameter sanity: width range and enough digits for the largest input.
  if ((BIN_W < MIN_BIN_W) || (BIN_W > MAX_BIN_W)) begin : g_bad_width
    $error("bin_to_bcd_iter: BIN_W=%0d outside 4..32", BIN_W);
  end
  if (DIGITS < bcd_digits_for(BIN_W)) begin : g_bad_digits
    $error("bin_to_bcd_iter: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  bcd_state_e         state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;

  logic [BCD_W-1:0]   bcd_corr;
  logic [SR_W-1:0]    sr_shift;
  logic [BIN_W-1:0]   operand;
  logic               accept;

  // Digit correction for the current BCD field, one instance per digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_in  (bcd_q[4*g +: 4]),
      .digit_out (bcd_corr[4*g +: 4])
    );
  end

  // Whole {BCD, binary} register after correction and a one-bit left shift.
  assign sr_shift = {bcd_corr, bin_q} << 1;

  assign accept = in_valid && in_ready_q && (state_q == IDLE);

`ifdef BIN_BCD_SIGNED_EN
  logic neg_q, neg_d;

  // Two's-complement magnitude; the most negative value maps to 2**(BIN_W-1).
  always_comb begin
    operand = bin_in;
    if (bin_in[BIN_W-1]) begin
      operand = ~bin_in + BIN_W'(1);
    end
  end
`else
  assign operand = bin_in;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    bcd_out_d   = bcd_out_q;
`ifdef BIN_BCD_SIGNED_EN
    neg_d       = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = CONV;
          bin_d      = operand;
          bcd_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          in_ready_d = 1'b0;
`ifdef BIN_BCD_SIGNED_EN
          neg_d      = bin_in[BIN_W-1];
`endif
        end
      end
      CONV: begin
        bcd_d = sr_shift[SR_W-1 -: BCD_W];
        bin_d = sr_shift[BIN_W-1:0];
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        // The last shift lands the final digits straight in the output register.
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          bcd_out_d   = sr_shift[SR_W-1 -: BCD_W];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          bcd_out_d   = '0;
          in_ready_d  = 1'b1;
`ifdef BIN_BCD_SIGNED_EN
          neg_d       = 1'b0;
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        bcd_out_d   = '0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // FSM and datapath state with asynchronous reset to an empty, idle block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bcd_out_q   <= '0;
`ifdef BIN_BCD_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bcd_out_q   <= bcd_out_d;
`ifdef BIN_BCD_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_out_q;
`ifdef BIN_BCD_SIGNED_EN
  assign neg       = neg_q;
`else
  assign neg       = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_iter.sv
// Self-checking bench for bin_to_bcd_iter (BIN_W=12, DIGITS=4).
// Expected results are queued at accept time and compared when the
// converter presents out_valid. Works with or without BIN_BCD_SIGNED_EN.
module tb_bin_to_bcd_iter;

  localparam int BIN_W  = 12;
  localparam int DIGITS = 4;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic                neg;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    bin_in;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                neg;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   accept_cyc = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  bin_to_bcd_iter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal digits by repeated division, sign from the MSB.
  function automatic exp_t model(input logic [BIN_W-1:0] v);
    exp_t        e;
    int unsigned mag;
    mag   = v;
    e.neg = 1'b0;
`ifdef BIN_BCD_SIGNED_EN
    if (v[BIN_W-1]) begin
      e.neg = 1'b1;
      mag   = (32'd1 << BIN_W) - v;
    end
`endif
    e.bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return e;
  endfunction

  task automatic send(input logic [BIN_W-1:0] v, output int acc);
    int n;
    n   = 0;
    acc = 0;
    @(negedge clk);
    bin_in   = v;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", n, 0);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(v));
    acc        = cyc + 1;
    accept_cyc = acc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin_in   = BIN_W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", sb.size(), 0);
  endtask

  // Output monitor: latency, result, hold behaviour and zero-when-idle.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_valid) check_eq("latency", cyc - accept_cyc, BIN_W);
        check_eq("result_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          check_eq("bcd_out", bcd_out, sb[0].bcd);
          check_eq("neg", neg, sb[0].neg);
          check_eq("in_ready_busy", in_ready, 0);
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        check_eq("bcd_idle_zero", bcd_out, 0);
        check_eq("neg_idle_zero", neg, 0);
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    reset     = 1'b1;
    in_valid  = 1'b0;
    bin_in    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_bcd_out", bcd_out, 0);
    check_eq("rst_neg", neg, 0);
    reset = 1'b0;

    // Corner values, converted back to back.
    send(12'd4095, a0);
    send(12'd0, a0);
    send(12'd1000, a0);
`ifdef BIN_BCD_SIGNED_EN
    send(12'h800, a0);
    send(12'hFFF, a0);
    send(12'h7FF, a0);
`endif
    drain();

    // Throughput with out_ready held high.
    send(BIN_W'($urandom), a0);
    send(BIN_W'($urandom), a1);
    send(BIN_W'($urandom), a2);
    check_eq("throughput_1", a1 - a0, BIN_W + 2);
    check_eq("throughput_2", a2 - a1, BIN_W + 2);
    drain();

    // Back-pressure: result held for 10 cycles, a second request ignored.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(12'h123, a0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_eq("hold_valid_seen", out_valid, 1);
    end
    bin_in   = 12'd555;
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("hold_still_valid", out_valid, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    repeat (20) @(negedge clk);

    // Reset during conversion discards the result.
    send(12'd2048, a0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_bcd_out", bcd_out, 0);
    check_eq("midrst_neg", neg, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    send(12'd7, a0);
    drain();

    // Random values with occasional back-pressure.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
      send(BIN_W'($urandom), a0);
      repeat ($urandom_range(BIN_W, BIN_W + 6)) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
